io_control_unit: RTL and testbench
==================================

IO_CONTROL_UNIT -- requirements
Module: io_control_unit

Interface
REQ-001 Parameter DATA_WIDTH, default `ISA_WIDTH (32), width of all data buses.
REQ-002 Parameter HOLD_CYCLES, default 4, display-hold length per CPU output request; legal range 1..2^16-1.
REQ-003 clk  in  1  system clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-high reset.
REQ-005 uart_mode  in  1  UART programming active; highest priority.
REQ-006 uart_complete  in  1  UART transfer finished.
REQ-007 in_req  in  1  CPU input request, level, held until in_ack.
REQ-008 out_req  in  1  CPU output request, level, held until out_ack.
REQ-009 out_data  in  DATA_WIDTH  value CPU wants displayed.
REQ-010 input_complete  in  1  single-cycle pulse from input unit: keypad entry finished.
REQ-011 input_data  in  DATA_WIDTH  current keypad value from input unit.
REQ-012 input_enable  out  1  enables input unit.
REQ-013 cpu_pause  out  1  stalls CPU pipeline.
REQ-014 in_ack  out  1  one-cycle pulse; rd_data valid.
REQ-015 rd_data  out  DATA_WIDTH  captured keypad value.
REQ-016 out_ack  out  1  one-cycle pulse; output request done.
REQ-017 display_value  out  DATA_WIDTH  value to seven-segment unit.
REQ-018 display_src  out  2  0 idle/CPU-held, 1 keypad echo, 2 UART.

Function
REQ-019 FSM states SHALL be IDLE, UART, INPUT, ACK_IN, OUTPUT, ACK_OUT; outputs decoded from registered state (Moore).
REQ-020 In any state, uart_mode=1 SHALL force next state UART; pending CPU request is abandoned without ack.
REQ-021 IDLE: uart_mode=0, only in_req -> INPUT; only out_req -> OUTPUT; both -> grant opposite of last_grant flag (round-robin); neither -> stay.
REQ-022 last_grant SHALL update on each IDLE->INPUT (=IN) or IDLE->OUTPUT (=OUT) transition.
REQ-023 UART: cpu_pause=1, display_src=2; exit to IDLE when uart_mode=0 and uart_complete=1, else stay.
REQ-024 INPUT: input_enable=1, cpu_pause=1, display_src=1, display_value=input_data (live echo); on input_complete=1 capture input_data into rd_data and go ACK_IN.
REQ-025 ACK_IN: in_ack=1, cpu_pause=0, input_enable=0, one cycle, then IDLE.
REQ-026 IDLE->OUTPUT transition SHALL load display_reg<=out_data and hold counter<=HOLD_CYCLES-1.
REQ-027 OUTPUT: cpu_pause=1, display_src=0; counter decrements each cycle; at counter=0 go ACK_OUT (OUTPUT lasts exactly HOLD_CYCLES cycles).
REQ-028 ACK_OUT: out_ack=1, cpu_pause=0, one cycle, then IDLE.
REQ-029 Outside INPUT, display_value SHALL equal display_reg; display_reg retains value until next OUTPUT load.
REQ-030 Latency: request sampled in IDLE at edge N -> input_enable/cpu_pause high from cycle N+1; input_complete at edge M -> in_ack high in cycle M+1.
REQ-031 input_complete outside INPUT SHALL be ignored; rd_data changes only on INPUT capture.
REQ-032 Requester still asserting in_req/out_req in IDLE after ack SHALL be treated as a new request.
REQ-033 Counter SHALL be 16 bits, never wrap below 0.

Reset
REQ-034 rst_n=1 SHALL immediately force IDLE, last_grant=OUT, rd_data=0, display_reg=0, counter=0, all 1-bit outputs 0, display_src=0, regardless of clock.
REQ-035 Reset mid-INPUT/OUTPUT SHALL drop the request with no ack; operation resumes from IDLE after release.

Verification
REQ-036 in_req=1, input_complete pulse with input_data=0x1234 after 10 cycles -> input_enable/cpu_pause high 10 cycles, in_ack 1 cycle, rd_data=0x1234.
REQ-037 out_req=1, out_data=0xABCD, HOLD_CYCLES=4 -> cpu_pause high exactly 4 cycles, out_ack next cycle, display_value=0xABCD thereafter.
REQ-038 in_req and out_req asserted together from reset, both re-requested after ack -> grant order INPUT, OUTPUT, INPUT.
REQ-039 uart_mode raised during INPUT -> next cycle UART, display_src=2, no in_ack; IDLE only after uart_mode=0 and uart_complete=1.
REQ-040 rst_n asserted mid-OUTPUT between clock edges -> outputs zero immediately, no out_ack, display_value=0.

Source files
------------

// File: rtl/io_control_unit.sv
// rtl/io_control_unit.sv - CPU I/O arbiter between keypad input, seven-segment output and UART programming
//
// Moore FSM that grants one CPU I/O request at a time and stalls the CPU while it is serviced.
// uart_mode overrides everything. When in_req and out_req arrive together they are granted
// round-robin.
//
// Ports:
//   clk, rst_n        clock; asynchronous reset, active HIGH despite the name
//   uart_mode         UART programming active (highest priority)
//   uart_complete     UART transfer finished
//   in_req / in_ack   CPU input request (level) / one-cycle ack, rd_data valid
//   out_req / out_ack CPU output request (level) / one-cycle ack
//   out_data          value the CPU wants displayed
//   input_complete    keypad entry finished (one-cycle pulse)
//   input_data        live keypad value
//   input_enable      enables the input unit
//   cpu_pause         stalls the CPU pipeline
//   rd_data           captured keypad value
//   display_value     value sent to the seven-segment unit
//   display_src       0 idle/CPU-held, 1 keypad echo, 2 UART

`ifndef ISA_WIDTH
`define ISA_WIDTH 32
`endif

module io_control_unit #(
  parameter int DATA_WIDTH  = `ISA_WIDTH,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  uart_mode,
  input  logic                  uart_complete,
  input  logic                  in_req,
  input  logic                  out_req,
  input  logic [DATA_WIDTH-1:0] out_data,
  input  logic                  input_complete,
  input  logic [DATA_WIDTH-1:0] input_data,
  output logic                  input_enable,
  output logic                  cpu_pause,
  output logic                  in_ack,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_ack,
  output logic [DATA_WIDTH-1:0] display_value,
  output logic [1:0]            display_src
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    UART    = 3'd1,
    INPUT   = 3'd2,
    ACK_IN  = 3'd3,
    OUTPUT  = 3'd4,
    ACK_OUT = 3'd5
  } state_t;

  localparam logic GRANT_IN  = 1'b0;
  localparam logic GRANT_OUT = 1'b1;

  // The counter is loaded with HOLD_CYCLES-1 so that OUTPUT lasts exactly HOLD_CYCLES cycles.
  localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);

  state_t                state;
  state_t                state_next;
  logic                  last_grant;
  logic [DATA_WIDTH-1:0] display_reg;
  logic [15:0]           counter;

  logic                  enter_input;
  logic                  enter_output;
  logic                  capture_input;

  always_comb begin
    state_next = state;
    if (uart_mode) begin
      // Any pending CPU request is abandoned without an ack.
      state_next = UART;
    end else begin
      case (state)
        IDLE: begin
          if (in_req && out_req) begin
            state_next = (last_grant == GRANT_IN) ? OUTPUT : INPUT;
          end else if (in_req) begin
            state_next = INPUT;
          end else if (out_req) begin
            state_next = OUTPUT;
          end
        end
        UART:    if (uart_complete) state_next = IDLE;
        INPUT:   if (input_complete) state_next = ACK_IN;
        ACK_IN:  state_next = IDLE;
        OUTPUT:  if (counter == 16'd0) state_next = ACK_OUT;
        ACK_OUT: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  assign enter_input   = (state == IDLE) && (state_next == INPUT);
  assign enter_output  = (state == IDLE) && (state_next == OUTPUT);
  assign capture_input = (state == INPUT) && (state_next == ACK_IN);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state       <= IDLE;
      last_grant  <= GRANT_OUT;
      rd_data     <= '0;
      display_reg <= '0;
      counter     <= 16'd0;
    end else begin
      state <= state_next;
      if (enter_input) begin
        last_grant <= GRANT_IN;
      end
      if (enter_output) begin
        last_grant  <= GRANT_OUT;
        display_reg <= out_data;
        counter     <= HOLD_LOAD;
      end else if ((state == OUTPUT) && (counter != 16'd0)) begin
        counter <= counter - 16'd1;
      end
      if (capture_input) begin
        rd_data <= input_data;
      end
    end
  end

  // Outputs depend on the registered state only, so reset clears them immediately.
  always_comb begin
    input_enable  = 1'b0;
    cpu_pause     = 1'b0;
    in_ack        = 1'b0;
    out_ack       = 1'b0;
    display_src   = 2'd0;
    display_value = display_reg;
    case (state)
      UART: begin
        cpu_pause   = 1'b1;
        display_src = 2'd2;
      end
      INPUT: begin
        input_enable  = 1'b1;
        cpu_pause     = 1'b1;
        display_src   = 2'd1;
        display_value = input_data;
      end
      ACK_IN:  in_ack = 1'b1;
      OUTPUT:  cpu_pause = 1'b1;
      ACK_OUT: out_ack = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_io_control_unit.sv
// tb/tb_io_control_unit.sv - scoreboard bench for io_control_unit
module tb_io_control_unit;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          uart_mode = 1'b0;
  logic          uart_complete = 1'b0;
  logic          in_req = 1'b0;
  logic          out_req = 1'b0;
  logic [DW-1:0] out_data = '0;
  logic          input_complete = 1'b0;
  logic [DW-1:0] input_data = '0;
  logic          input_enable;
  logic          cpu_pause;
  logic          in_ack;
  logic [DW-1:0] rd_data;
  logic          out_ack;
  logic [DW-1:0] display_value;
  logic [1:0]    display_src;

  io_control_unit #(.DATA_WIDTH(DW), .HOLD_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .uart_mode(uart_mode), .uart_complete(uart_complete),
    .in_req(in_req), .out_req(out_req), .out_data(out_data),
    .input_complete(input_complete), .input_data(input_data),
    .input_enable(input_enable), .cpu_pause(cpu_pause), .in_ack(in_ack),
    .rd_data(rd_data), .out_ack(out_ack), .display_value(display_value),
    .display_src(display_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          is_out;
    logic [DW-1:0] data;
    int            pause;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Keypad model: acts at posedge+2, after the main process has updated its controls.
  int            kp_delay = 10;
  logic [DW-1:0] kp_value = 32'h1234;
  logic [DW-1:0] kp_live  = 32'h00AA;
  logic          stray_req = 1'b0;

  initial begin
    int en_cnt;
    en_cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      input_complete = 1'b0;
      input_data     = kp_live;
      if (input_enable) begin
        en_cnt++;
        if (en_cnt == kp_delay) begin
          input_complete = 1'b1;
          input_data     = kp_value;
          kp_value       = kp_value + 1;
        end
      end else begin
        en_cnt = 0;
        if (stray_req) begin
          input_complete = 1'b1;
          input_data     = 32'h5555;
        end
      end
    end
  end

  // Monitor: pops the expected transaction on every ack and checks data and stall length.
  int pause_run = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      pause_run = 0;
    end else if (in_ack || out_ack) begin
      if (q.size() == 0) begin
        check("unexpected_ack", {30'd0, in_ack, out_ack}, '0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("ack_kind", {31'd0, out_ack}, {31'd0, e.is_out});
        check("ack_both", {31'd0, in_ack & out_ack}, '0);
        if (e.is_out) check("out_display", display_value, e.data);
        else          check("in_rd_data", rd_data, e.data);
        check("pause_len", pause_run, e.pause);
      end
      pause_run = 0;
    end else if (cpu_pause) begin
      pause_run++;
    end else begin
      pause_run = 0;
    end
  end

  task automatic wait_acks(input int n);
    int got;
    got = 0;
    for (int i = 0; i < 300 && got < n; i++) begin
      tick();
      if (in_ack || out_ack) got++;
    end
    if (got < n) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout actual=%0d expected=%0d", got, n);
    end
  endtask

  initial begin
    // Reset takes effect without a clock edge.
    #1 rst_n = 1'b1;
    #1;
    check("rst_pause", {31'd0, cpu_pause}, '0);
    check("rst_enable", {31'd0, input_enable}, '0);
    check("rst_acks", {30'd0, in_ack, out_ack}, '0);
    check("rst_rd_data", rd_data, '0);
    check("rst_display", display_value, '0);
    check("rst_src", {30'd0, display_src}, '0);
    tick();
    tick();
    rst_n = 1'b0;
    tick();

    // Single input request, completion after 10 cycles in INPUT.
    kp_delay = 10;
    kp_value = 32'h1234;
    q.push_back('{1'b0, 32'h1234, 10});
    in_req = 1'b1;
    tick();
    #2;
    check("in_enable", {31'd0, input_enable}, 32'd1);
    check("in_pause", {31'd0, cpu_pause}, 32'd1);
    check("in_src", {30'd0, display_src}, 32'd1);
    check("in_echo", display_value, 32'h00AA);
    wait_acks(1);
    in_req = 1'b0;
    tick();
    // Stray keypad completion in IDLE is ignored.
    stray_req = 1'b1;
    tick();
    stray_req = 1'b0;
    tick();
    tick();
    check("stray_rd_data", rd_data, 32'h1234);
    check("stray_pause", {31'd0, cpu_pause}, '0);

    // Single output request, 4-cycle hold.
    out_data = 32'hABCD;
    q.push_back('{1'b1, 32'hABCD, 4});
    out_req = 1'b1;
    wait_acks(1);
    out_req = 1'b0;
    tick();
    check("out_hold_value", display_value, 32'hABCD);
    check("out_hold_src", {30'd0, display_src}, '0);
    tick();
    tick();
    check("out_hold_value2", display_value, 32'hABCD);

    // Both requests from reset: round-robin IN, OUT, IN.
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    kp_delay = 3;
    kp_value = 32'h1111;
    out_data = 32'h2222;
    q.push_back('{1'b0, 32'h1111, 3});
    q.push_back('{1'b1, 32'h2222, 4});
    q.push_back('{1'b0, 32'h1112, 3});
    in_req  = 1'b1;
    out_req = 1'b1;
    wait_acks(3);
    in_req  = 1'b0;
    out_req = 1'b0;
    tick();
    tick();
    check("rr_idle_pause", {31'd0, cpu_pause}, '0);

    // UART takes over mid-INPUT; request abandoned without ack.
    kp_delay = 1000;
    in_req = 1'b1;
    tick();
    tick();
    tick();
    uart_mode = 1'b1;
    tick();
    in_req = 1'b0;
    check("uart_src", {30'd0, display_src}, 32'd2);
    check("uart_pause", {31'd0, cpu_pause}, 32'd1);
    check("uart_enable", {31'd0, input_enable}, '0);
    check("uart_no_ack", {31'd0, in_ack}, '0);
    uart_complete = 1'b1;
    tick();
    check("uart_mode_held", {30'd0, display_src}, 32'd2);
    uart_mode = 1'b0;
    uart_complete = 1'b0;
    tick();
    check("uart_wait_complete", {30'd0, display_src}, 32'd2);
    uart_complete = 1'b1;
    tick();
    uart_complete = 1'b0;
    check("uart_exit_src", {30'd0, display_src}, '0);
    check("uart_exit_pause", {31'd0, cpu_pause}, '0);
    tick();
    check("uart_idle_pause", {31'd0, cpu_pause}, '0);

    // Reset asserted between edges during OUTPUT.
    out_data = 32'h5A5A;
    out_req = 1'b1;
    tick();
    tick();
    #2;
    rst_n = 1'b1;
    #1;
    check("midrst_pause", {31'd0, cpu_pause}, '0);
    check("midrst_display", display_value, '0);
    check("midrst_src", {30'd0, display_src}, '0);
    check("midrst_ack", {31'd0, out_ack}, '0);
    out_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("midrst_display_after", display_value, '0);

    // Operation resumes from IDLE.
    out_data = 32'h0F0F;
    q.push_back('{1'b1, 32'h0F0F, 4});
    out_req = 1'b1;
    wait_acks(1);
    out_req = 1'b0;
    tick();
    check("resume_display", display_value, 32'h0F0F);
    tick();
    tick();
    check("queue_empty", q.size(), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
